// File: rtl/button_debounce.sv
// Debounces an active-low push-button: two-flop synchroniser, qualification FSM,
// clean level output and one-cycle press / release / long-press pulses.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BUT1,
  output logic BUT_DB,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG
);

  localparam int unsigned QW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
  // A LONG_CYCLES of zero disables the long-press pulse entirely.
  localparam bit LONG_EN = (LONG_CYCLES != 0);
  localparam logic [HW-1:0] H_LAST = LONG_EN ? HW'(LONG_CYCLES - 1) : {HW{1'b0}};

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  state_e        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          long_done_q, long_done_d;
  logic          but_db_q, but_db_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          held_s;

  // Next-state, counter and pulse computation.
  always_comb begin
    sync1_d     = BUT1;
    sync2_d     = sync1_q;
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    but_db_d    = but_db_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    held_s      = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_WAIT);

    // Hold timing runs only while the debounced level says pressed.
    if (held_s) begin
      if (hcnt_q != H_LAST) begin
        hcnt_d = hcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q;
      end
      if (LONG_EN && (hcnt_q == H_LAST) && !long_done_q) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        long_d      = 1'b0;
      end
    end else begin
      hcnt_d = hcnt_q;
    end

    case (state_q)
      ST_RELEASED: begin
        if (!sync2_q) begin
          state_d = ST_PRESS_WAIT;
          qcnt_d  = {QW{1'b0}};
        end else begin
          state_d = ST_RELEASED;
        end
      end
      ST_PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = ST_RELEASED;
        end else if (qcnt_q == Q_LAST) begin
          state_d     = ST_PRESSED;
          but_db_d    = 1'b0;
          press_d     = 1'b1;
          hcnt_d      = {HW{1'b0}};
          long_done_d = 1'b0;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (sync2_q) begin
          state_d = ST_RELEASE_WAIT;
          qcnt_d  = {QW{1'b0}};
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_PRESSED;
        end else if (qcnt_q == Q_LAST) begin
          state_d   = ST_RELEASED;
          but_db_d  = 1'b1;
          release_d = 1'b1;
        end else begin
          qcnt_d = qcnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = ST_RELEASED;
        but_db_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any event in progress.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_RELEASED;
      qcnt_q      <= {QW{1'b0}};
      hcnt_q      <= {HW{1'b0}};
      long_done_q <= 1'b0;
      but_db_q    <= 1'b1;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      hcnt_q      <= hcnt_d;
      long_done_q <= long_done_d;
      but_db_q    <= but_db_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign BUT_DB  = but_db_q;
  assign PRESS   = press_q;
  assign RELEASE = release_q;
  assign LONG    = long_q;

endmodule
